// File: rtl/rans_interleaved_enc.sv
// rtl/rans_interleaved_enc.sv - interleaved rANS encoder with one shared iterative datapath
// and a lane-state register file, valid/ready streams and a lane-state flush.
module rans_interleaved_enc #(
   parameter int RESOLUTION   = 10,
   parameter int SYMBOL_WIDTH = 8,
   parameter int NUM_RANS     = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    freq_wr_i,
   input  logic [SYMBOL_WIDTH-1:0] freq_addr_i,
   input  logic [RESOLUTION:0]     freq_i,
   input  logic [RESOLUTION-1:0]   cum_freq_i,
   input  logic                    symb_valid_i,
   output logic                    symb_ready_o,
   input  logic [SYMBOL_WIDTH-1:0] symb_i,
   input  logic                    flush_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [7:0]              out_data_o,
   output logic                    out_last_o,
   output logic                    busy_o,
   output logic                    err_o
);

   localparam int STATE_W     = RESOLUTION + 8;
   localparam int FLUSH_BYTES = (STATE_W + 7) / 8;
   localparam int PAD_W       = 8 * FLUSH_BYTES;
   localparam int LANE_W      = (NUM_RANS > 1) ? $clog2(NUM_RANS) : 1;
   localparam int BYTE_W      = (FLUSH_BYTES > 1) ? $clog2(FLUSH_BYTES) : 1;
   localparam int REM_W       = RESOLUTION + 1;
   localparam logic [STATE_W-1:0] X_INIT = STATE_W'(1) << RESOLUTION;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RENORM, S_DIV, S_UPDATE, S_FLUSH} state_t;

   state_t state_q, state_d;

   logic [2*RESOLUTION:0] tab_mem [2**SYMBOL_WIDTH];
   logic [2*RESOLUTION:0] rd_q;
   logic [STATE_W-1:0]    x_q [NUM_RANS];
   logic [LANE_W-1:0]     lane_q;
   logic [REM_W-1:0]      rem_q;
   logic [7:0]            lo_q;
   logic [7:0]            quot_q;
   logic [2:0]            cnt_q;
   logic                  skip_q;
   logic                  err_q;
   logic [LANE_W-1:0]     flane_q;
   logic [BYTE_W-1:0]     fbyte_q;
   logic                  fdone_q;
   logic                  ov_q;
   logic [7:0]            od_q;
   logic                  ol_q;

   logic [RESOLUTION:0]   f_w;
   logic [RESOLUTION-1:0] c_w;
   logic [STATE_W-1:0]    x_cur;
   logic                  emit_need;
   logic [REM_W:0]        trial;
   logic [REM_W:0]        f_ext;
   logic                  div_ge;
   logic [PAD_W-1:0]      flush_word;
   logic                  flush_last;
   logic                  out_fire;
   logic                  out_free;
   logic                  out_load;
   logic [7:0]            out_byte;
   logic                  out_last_d;

   assign f_w        = rd_q[2*RESOLUTION -: RESOLUTION+1];
   assign c_w        = rd_q[RESOLUTION-1:0];
   assign x_cur      = x_q[lane_q];
   assign emit_need  = {1'b0, x_cur} >= ((STATE_W+1)'(f_w) << 8);
   assign trial      = {rem_q, lo_q[7]};
   assign f_ext      = (REM_W+1)'(f_w);
   assign div_ge     = trial >= f_ext;
   assign flush_word = PAD_W'(x_q[flane_q]);
   assign flush_last = (flane_q == '0) && (fbyte_q == BYTE_W'(FLUSH_BYTES-1));
   assign out_fire   = ov_q && out_ready_i;
   assign out_free   = !ov_q || out_ready_i;

   assign symb_ready_o = (state_q == S_IDLE) && !flush_i;
   assign busy_o       = (state_q != S_IDLE);
   assign err_o        = err_q;
   assign out_valid_o  = ov_q;
   assign out_data_o   = od_q;
   assign out_last_o   = ol_q;

   // Table is read every idle cycle so the accepting edge captures the entry for symb_i.
   always_ff @(posedge clk_i) begin
      if (freq_wr_i && state_q == S_IDLE)
         tab_mem[freq_addr_i] <= {freq_i, cum_freq_i};
      if (state_q == S_IDLE)
         rd_q <= tab_mem[symb_i];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      out_load   = 1'b0;
      out_byte   = '0;
      out_last_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush_i)           state_d = S_FLUSH;
            else if (symb_valid_i) state_d = S_LOOKUP;
         end
         // A zero-frequency symbol still spends the UPDATE slot, but writes nothing.
         S_LOOKUP: state_d = (f_w == '0) ? S_UPDATE : S_RENORM;
         S_RENORM: begin
            if (emit_need) begin
               if (out_free) begin
                  out_load = 1'b1;
                  out_byte = x_cur[7:0];
               end
            end else begin
               state_d = S_DIV;
            end
         end
         S_DIV:    if (cnt_q == 3'd7) state_d = S_UPDATE;
         S_UPDATE: state_d = S_IDLE;
         S_FLUSH: begin
            if (fdone_q) begin
               if (out_fire) state_d = S_IDLE;
            end else if (out_free) begin
               out_load   = 1'b1;
               out_byte   = flush_word[{fbyte_q, 3'b000} +: 8];
               out_last_d = flush_last;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_RANS; i++) x_q[i] <= X_INIT;
         lane_q  <= '0;
         rem_q   <= '0;
         lo_q    <= '0;
         quot_q  <= '0;
         cnt_q   <= '0;
         skip_q  <= 1'b0;
         err_q   <= 1'b0;
         flane_q <= '0;
         fbyte_q <= '0;
         fdone_q <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         ol_q    <= 1'b0;
      end else begin
         if (out_load) begin
            ov_q <= 1'b1;
            od_q <= out_byte;
            ol_q <= out_last_d;
         end else if (out_fire) begin
            ov_q <= 1'b0;
            ol_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (flush_i) begin
                  flane_q <= LANE_W'(NUM_RANS-1);
                  fbyte_q <= '0;
                  fdone_q <= 1'b0;
               end
            end
            S_LOOKUP: begin
               skip_q <= (f_w == '0);
               if (f_w == '0) err_q <= 1'b1;
            end
            S_RENORM: begin
               if (emit_need) begin
                  if (out_free) x_q[lane_q] <= x_cur >> 8;
               end else begin
                  rem_q  <= REM_W'(x_cur >> 8);
                  lo_q   <= x_cur[7:0];
                  quot_q <= '0;
                  cnt_q  <= '0;
               end
            end
            // Restoring division: x < f<<8 here, so the quotient fits in 8 bits.
            S_DIV: begin
               rem_q  <= REM_W'(div_ge ? trial - f_ext : trial);
               lo_q   <= {lo_q[6:0], 1'b0};
               quot_q <= {quot_q[6:0], div_ge};
               cnt_q  <= cnt_q + 3'd1;
            end
            S_UPDATE: begin
               if (!skip_q) begin
                  x_q[lane_q] <= (STATE_W'(quot_q) << RESOLUTION) + STATE_W'(rem_q) + STATE_W'(c_w);
                  lane_q      <= (lane_q == LANE_W'(NUM_RANS-1)) ? '0 : lane_q + LANE_W'(1);
               end
            end
            S_FLUSH: begin
               if (fdone_q) begin
                  if (out_fire) begin
                     for (int i = 0; i < NUM_RANS; i++) x_q[i] <= X_INIT;
                     lane_q <= '0;
                  end
               end else if (out_free) begin
                  if (flush_last) begin
                     fdone_q <= 1'b1;
                  end else if (fbyte_q == BYTE_W'(FLUSH_BYTES-1)) begin
                     fbyte_q <= '0;
                     flane_q <= flane_q - LANE_W'(1);
                  end else begin
                     fbyte_q <= fbyte_q + BYTE_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rans_interleaved_enc.sv
// tb/tb_rans_interleaved_enc.sv - directed, table-driven bench for rans_interleaved_enc
// (RESOLUTION=10, SYMBOL_WIDTH=8, NUM_RANS=4).
module tb_rans_interleaved_enc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freq_wr = 1'b0;
   logic [7:0]  freq_addr = '0;
   logic [10:0] freq = '0;
   logic [9:0]  cum = '0;
   logic        symb_valid = 1'b0;
   logic        symb_ready;
   logic [7:0]  symb = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_last;
   logic        busy;
   logic        err;

   int total = 0;
   int bad   = 0;

   rans_interleaved_enc #(.RESOLUTION(10), .SYMBOL_WIDTH(8), .NUM_RANS(4)) dut (
      .clk_i(clk), .rst_i(rst), .freq_wr_i(freq_wr), .freq_addr_i(freq_addr),
      .freq_i(freq), .cum_freq_i(cum), .symb_valid_i(symb_valid), .symb_ready_o(symb_ready),
      .symb_i(symb), .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_last_o(out_last), .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] sym;
      int         lat;
      int         nb;
      logic [7:0] b0;
      logic [7:0] b1;
      logic       err;
   } vec_t;

   vec_t vecs [14];
   logic [7:0] fl_exp [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, 32'(symb_ready), 32'd1);
      check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
      check({tag, "_odata"}, 32'(out_data), 32'd0);
      check({tag, "_olast"}, 32'(out_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      symb_valid = 1'b0;
      flush      = 1'b0;
      freq_wr    = 1'b0;
      out_ready  = 1'b1;
      rst        = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic write_tab(input logic [7:0] s, input logic [10:0] f, input logic [9:0] c);
      freq_wr = 1'b1; freq_addr = s; freq = f; cum = c;
      @(negedge clk);
      freq_wr = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!symb_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic encode(input logic [7:0] s, output int lat, output int nb,
                         output logic [7:0] b0, output logic [7:0] b1);
      int w;
      wait_ready(w);
      symb_valid = 1'b1;
      symb       = s;
      @(posedge clk);
      @(negedge clk);
      symb_valid = 1'b0;
      lat = 0; nb = 0; b0 = '0; b1 = '0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (out_valid && out_ready) begin
            if (nb == 0) b0 = out_data;
            if (nb == 1) b1 = out_data;
            nb++;
         end
         if (symb_ready) break;
      end
   endtask

   task automatic flush_check(input string name, input logic with_valid);
      symb_valid = with_valid;
      symb       = 8'd7;
      flush      = 1'b1;
      #1;
      check({name, "_ready_low"}, 32'(symb_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      flush      = 1'b0;
      symb_valid = 1'b0;
      check({name, "_first_delay"}, 32'(out_valid), 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check($sformatf("%s_byte%0d", name, i), {22'd0, out_valid, out_last, out_data},
               {22'd0, 1'b1, (i == 11), fl_exp[i]});
      end
      @(negedge clk);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic set_flush_exp(input logic [31:0] l3, input logic [31:0] l2,
                                input logic [31:0] l1, input logic [31:0] l0);
      logic [31:0] lv [4];
      lv[0] = l3; lv[1] = l2; lv[2] = l1; lv[3] = l0;
      for (int i = 0; i < 4; i++) begin
         fl_exp[3*i]   = lv[i][7:0];
         fl_exp[3*i+1] = lv[i][15:8];
         fl_exp[3*i+2] = lv[i][23:16];
      end
   endtask

   initial begin
      int lat, nb, n;
      logic [7:0] b0, b1;

      //          sym    lat nb  b0     b1     err
      vecs[0]  = '{8'd7,  12, 1, 8'h00, 8'h00, 1'b0};
      vecs[1]  = '{8'd3,  11, 0, 8'h00, 8'h00, 1'b0};
      vecs[2]  = '{8'd11, 11, 0, 8'h00, 8'h00, 1'b0};
      vecs[3]  = '{8'd10, 12, 1, 8'h00, 8'h00, 1'b0};
      vecs[4]  = '{8'd7,  12, 1, 8'h05, 8'h00, 1'b0};
      vecs[5]  = '{8'd3,  11, 0, 8'h00, 8'h00, 1'b0};
      vecs[6]  = '{8'd12, 12, 1, 8'h38, 8'h00, 1'b0};
      vecs[7]  = '{8'd9,  11, 0, 8'h00, 8'h00, 1'b0};
      vecs[8]  = '{8'd7,  12, 1, 8'h05, 8'h00, 1'b0};
      vecs[9]  = '{8'd13,  2, 0, 8'h00, 8'h00, 1'b1};
      vecs[10] = '{8'd7,  12, 1, 8'h00, 8'h00, 1'b1};
      vecs[11] = '{8'd7,  12, 1, 8'hE9, 8'h00, 1'b1};
      vecs[12] = '{8'd3,  11, 0, 8'h00, 8'h00, 1'b1};
      vecs[13] = '{8'd7,  13, 2, 8'h05, 8'h00, 1'b1};

      do_reset();
      check_reset_vals("reset");

      set_flush_exp(32'd1024, 32'd1024, 32'd1024, 32'd1024);
      flush_check("flush_init", 1'b0);

      write_tab(8'd3, 11'd512, 10'd0);
      write_tab(8'd7, 11'd1, 10'd5);
      write_tab(8'd9, 11'd1024, 10'd0);
      write_tab(8'd10, 11'd3, 10'd100);
      write_tab(8'd11, 11'd300, 10'd700);
      write_tab(8'd12, 11'd2, 10'd1000);
      write_tab(8'd13, 11'd0, 10'd0);

      for (int i = 0; i < 14; i++) begin
         encode(vecs[i].sym, lat, nb, b0, b1);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_nbytes", i), 32'(nb), 32'(vecs[i].nb));
         check($sformatf("vec%0d_bytes", i), {16'd0, b0, b1}, {16'd0, vecs[i].b0, vecs[i].b1});
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      end
      set_flush_exp(32'd2149, 32'd31749, 32'd16389, 32'd1029);
      flush_check("flush_seq", 1'b0);

      // Output stall: the first byte parks in the output register, the second must wait.
      do_reset();
      check("stall_err_cleared", 32'(err), 32'd0);
      out_ready = 1'b0;
      encode(8'd7, lat, nb, b0, b1);
      check("stall_first_lat", 32'(lat), 32'd12);
      repeat (3) @(negedge clk);
      check("stall_held_byte", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h00});
      symb_valid = 1'b1;
      symb       = 8'd7;
      @(posedge clk);
      @(negedge clk);
      symb_valid = 1'b0;
      repeat (30) @(negedge clk);
      check("stall_stuck", {29'd0, symb_ready, busy, out_valid}, {29'd0, 1'b0, 1'b1, 1'b1});
      check("stall_data_stable", 32'(out_data), 32'h00);
      out_ready = 1'b1;
      nb = 1;
      n  = 0;
      while (n < 50) begin
         @(negedge clk);
         n++;
         if (out_valid && out_ready) nb++;
         if (symb_ready) break;
      end
      check("stall_resume", 32'(symb_ready), 32'd1);
      check("stall_bytes", 32'(nb), 32'd2);
      set_flush_exp(32'd1024, 32'd1024, 32'd4101, 32'd4101);
      flush_check("flush_stall", 1'b0);

      // Table writes while busy are dropped.
      do_reset();
      symb_valid = 1'b1;
      symb       = 8'd3;
      @(posedge clk);
      @(negedge clk);
      symb_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("wr_during_div_busy", 32'(busy), 32'd1);
      write_tab(8'd3, 11'd1, 10'd5);
      wait_ready(n);
      check("wr_during_div_done", 32'(symb_ready), 32'd1);
      encode(8'd3, lat, nb, b0, b1);
      check("wr_ignored_lat", 32'(lat), 32'd11);
      check("wr_ignored_nb", 32'(nb), 32'd0);
      set_flush_exp(32'd1024, 32'd1024, 32'd2048, 32'd2048);
      flush_check("flush_wr", 1'b0);

      // Reset in the middle of a divide, with a byte parked in the output register.
      do_reset();
      out_ready  = 1'b0;
      symb_valid = 1'b1;
      symb       = 8'd7;
      @(posedge clk);
      @(negedge clk);
      symb_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_div_state", {30'd0, busy, out_valid}, {30'd0, 1'b1, 1'b1});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      check_reset_vals("mid_div_reset");
      set_flush_exp(32'd1024, 32'd1024, 32'd1024, 32'd1024);
      flush_check("flush_after_rst", 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
